// File: rtl/div16_seq_pkg.sv
// ==========================================================================
// div16_seq_pkg : shared state type and constants for the div16_seq divider
// Rev 1.0
// ==========================================================================
`default_nettype none

package div16_seq_pkg;

    localparam int DIV_W = 16;

    localparam logic [DIV_W-1:0] DIV_ZERO_Q = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/div16_seq_cla.sv
// ==========================================================================
// CLA_16Bit : 16-bit carry-lookahead adder/subtractor (C_in=1: S=B-A, C_out=borrow)
// Rev 1.0
// ==========================================================================
`default_nettype none

module CLA_16Bit (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        C_in,
    output logic [15:0] S,
    output logic        C_out
);

    logic [15:0] a_eff;
    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] c;
    logic [3:0]  grp_p;
    logic [3:0]  grp_g;
    logic [4:0]  gc;

    assign a_eff = A ^ {16{C_in}};
    assign p     = a_eff ^ B;
    assign g     = a_eff & B;

    genvar n;
    generate
        for (n = 0; n < 4; n++) begin : g_grp
            logic [3:0] pp;
            logic [3:0] gg;
            logic       c0;

            assign pp = p[4*n +: 4];
            assign gg = g[4*n +: 4];
            assign c0 = gc[n];

            assign c[4*n]   = c0;
            assign c[4*n+1] = gg[0] | (pp[0] & c0);
            assign c[4*n+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c0);
            assign c[4*n+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                            | (pp[2] & pp[1] & pp[0] & c0);

            assign grp_g[n] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                            | (pp[3] & pp[2] & pp[1] & gg[0]);
            assign grp_p[n] = &pp;
        end
    endgenerate

    // Second lookahead level across the four 4-bit groups
    assign gc[0] = C_in;
    assign gc[1] = grp_g[0] | (grp_p[0] & gc[0]);
    assign gc[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & gc[0]);
    assign gc[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                 | (grp_p[2] & grp_p[1] & grp_p[0] & gc[0]);
    assign gc[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                 | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                 | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & gc[0]);

    assign S     = p ^ c;
    assign C_out = gc[4] ^ C_in;

endmodule

`default_nettype wire

// File: rtl/div16_seq.sv
// ==========================================================================
// div16_seq : sequential 16-bit radix-2 restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement truncating division. Rev 1.0
// ==========================================================================
`default_nettype none

module div16_seq
    import div16_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] quotient,
    output logic [DIV_W-1:0] remainder,
    output logic             div_by_zero,
    output logic             ovf
);

    localparam logic [3:0] LAST_CNT = 4'(DIV_W - 1);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             finish;
    logic [DIV_W-1:0] rem_q;
    logic [DIV_W-1:0] quo_q;
    logic [DIV_W-1:0] dvs_q;
    logic [3:0]       count;
    logic             zero_q;
    logic [DIV_W-1:0] dividend_mag;
    logic [DIV_W-1:0] divisor_mag;
    logic [DIV_W-1:0] trial;
    logic [DIV_W-1:0] diff;
    logic [DIV_W-1:0] rem_nxt;
    logic [DIV_W-1:0] quo_nxt;
    logic [DIV_W-1:0] q_fin;
    logic [DIV_W-1:0] r_fin;
    logic             borrow;
    logic             success;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: accept = start;
            RUN: begin
                busy   = 1'b1;
                finish = (count == 4'd0);
            end
            DONE: begin
                done   = 1'b1;
                accept = start;
            end
            default: ;
        endcase
        if (accept) begin
            state_next = RUN;
        end else if (finish) begin
            state_next = DONE;
        end else if (state != RUN) begin
            state_next = IDLE;
        end
    end

`ifdef DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;
    logic ovf_pend;
    logic ovf_q;

    assign dividend_mag = dividend[DIV_W-1] ? (~dividend + 16'd1) : dividend;
    assign divisor_mag  = divisor[DIV_W-1]  ? (~divisor + 16'd1)  : divisor;
    assign q_fin        = neg_q ? (~quo_nxt + 16'd1) : quo_nxt;
    assign r_fin        = neg_r ? (~rem_nxt + 16'd1) : rem_nxt;
    assign ovf          = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            ovf_pend <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            neg_q    <= dividend[DIV_W-1] ^ divisor[DIV_W-1];
            neg_r    <= dividend[DIV_W-1];
            ovf_pend <= (dividend == 16'h8000) && (divisor == 16'hFFFF);
            ovf_q    <= 1'b0;
        end else if (finish) begin
            ovf_q    <= ovf_pend;
        end
    end
`else
    assign dividend_mag = dividend;
    assign divisor_mag  = divisor;
    assign q_fin        = quo_nxt;
    assign r_fin        = rem_nxt;
    assign ovf          = 1'b0;
`endif

    // R[15] acts as the 17th trial bit: when set, trial+2^16 always exceeds the divisor
    assign trial   = {rem_q[DIV_W-2:0], quo_q[DIV_W-1]};
    assign success = rem_q[DIV_W-1] | ~borrow;
    assign rem_nxt = success ? diff : trial;
    assign quo_nxt = {quo_q[DIV_W-2:0], success};

    CLA_16Bit u_cla (
        .A     (dvs_q),
        .B     (trial),
        .C_in  (1'b1),
        .S     (diff),
        .C_out (borrow)
    );

    // A zero divisor makes one pass through RUN; quo_q then carries the raw dividend
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            count       <= 4'd0;
            zero_q      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            rem_q       <= '0;
            quo_q       <= (divisor == '0) ? dividend : dividend_mag;
            dvs_q       <= divisor_mag;
            count       <= (divisor == '0) ? 4'd0 : LAST_CNT;
            zero_q      <= (divisor == '0);
            div_by_zero <= 1'b0;
        end else if (busy) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            if (finish) begin
                if (zero_q) begin
                    quotient    <= DIV_ZERO_Q;
                    remainder   <= quo_q;
                    div_by_zero <= 1'b1;
                end else begin
                    quotient    <= q_fin;
                    remainder   <= r_fin;
                end
            end else begin
                count <= count - 4'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_div16_seq.sv
// ==========================================================================
// tb_div16_seq : scoreboard bench for div16_seq with directed vectors. Rev 1.0
// ==========================================================================
`default_nettype none

module tb_div16_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dividend = 16'd0;
    logic [15:0] divisor = 16'd0;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        ovf;

    div16_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        logic        ovf;
        int          lat;
        int          t0;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   fails   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        vectors++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (busy && done) begin
                vectors++;
                fails++;
                $display("FAIL busy_done_overlap: got busy=1 done=1, required not both");
            end
            if (done) begin
                if (sb.size() == 0) begin
                    vectors++;
                    fails++;
                    $display("FAIL unexpected_done: got done=1, required no pending request");
                end else begin
                    e = sb.pop_front();
                    check({e.name, " quotient"}, quotient, e.q);
                    check({e.name, " remainder"}, remainder, e.r);
                    check({e.name, " div_by_zero"}, 16'(div_by_zero), 16'(e.dbz));
                    check({e.name, " ovf"}, 16'(ovf), 16'(e.ovf));
                    check({e.name, " latency"}, 16'(cyc - e.t0), 16'(e.lat));
                end
            end
        end
    end

    task automatic issue(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [15:0] er,
                         input logic edbz, input logic eovf);
        exp_t e;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        e.q    = eq;
        e.r    = er;
        e.dbz  = edbz;
        e.ovf  = eovf;
        e.lat  = (b == 16'd0) ? 1 : 16;
        e.t0   = cyc;
        e.name = name;
        sb.push_back(e);
        check({name, " busy_after_accept"}, 16'(busy), 16'd1);
        check({name, " dbz_cleared_on_accept"}, 16'(div_by_zero), 16'd0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        if (!done) begin
            vectors++;
            fails++;
            $display("FAIL done_timeout: got no done in 40 cycles, required done pulse");
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation time limit, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset busy", 16'(busy), 16'd0);
        check("reset done", 16'(done), 16'd0);
        check("reset quotient", quotient, 16'h0000);
        check("reset remainder", remainder, 16'h0000);
        check("reset div_by_zero", 16'(div_by_zero), 16'd0);
        check("reset ovf", 16'(ovf), 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue("100/7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0);
        wait_done();
`ifdef DIV_SIGNED_EN
        issue("FFFF/8001", 16'hFFFF, 16'h8001, 16'h0000, 16'hFFFF, 1'b0, 1'b0);
`else
        issue("FFFF/8001", 16'hFFFF, 16'h8001, 16'h0001, 16'h7FFE, 1'b0, 1'b0);
`endif
        wait_done();
        issue("FFFF/1", 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
        wait_done();
        issue("1234/0", 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, 1'b0);
        wait_done();
        issue("10/3", 16'd10, 16'd3, 16'd3, 16'd1, 1'b0, 1'b0);
        wait_done();
        issue("5/9", 16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 1'b0);
        wait_done();

        // start during RUN must not disturb the request in flight
        issue("100/7 with stray start", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        dividend = 16'd5;
        divisor  = 16'd5;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_done();

        // back-to-back: start in the DONE cycle
        issue("1000/10", 16'd1000, 16'd10, 16'd100, 16'd0, 1'b0, 1'b0);
        wait_done();
`ifdef DIV_SIGNED_EN
        issue("FFFF/256 b2b", 16'hFFFF, 16'd256, 16'h0000, 16'hFFFF, 1'b0, 1'b0);
`else
        issue("FFFF/256 b2b", 16'hFFFF, 16'd256, 16'd255, 16'd255, 1'b0, 1'b0);
`endif
        wait_done();

        // asynchronous reset in the middle of RUN
        @(negedge clk);
        issue("1000/7 aborted", 16'd1000, 16'd7, 16'd142, 16'd6, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun reset busy", 16'(busy), 16'd0);
        check("midrun reset done", 16'(done), 16'd0);
        check("midrun reset quotient", quotient, 16'h0000);
        check("midrun reset remainder", remainder, 16'h0000);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        issue("200/9 after reset", 16'd200, 16'd9, 16'd22, 16'd2, 1'b0, 1'b0);
        wait_done();

`ifdef DIV_SIGNED_EN
        issue("-7/2", 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0);
        wait_done();
        issue("7/-2", 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 1'b0);
        wait_done();
        issue("8000/FFFF", 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1);
        wait_done();
        issue("-100/0", 16'hFF9C, 16'h0000, 16'hFFFF, 16'hFF9C, 1'b1, 1'b0);
        wait_done();
`endif

        repeat (3) @(negedge clk);
        check("scoreboard drained", 16'(sb.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

`default_nettype wire
